// File: rtl/fetch_pkg.sv
// Shared constants and entry layout for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned DEFAULT_XLEN  = 32;

    // Decode-queue entry for the default 32-bit core; the top builds the same
    // layout at its own XLEN.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush, generic entry type and occupancy count.
// The head is read combinationally from storage; DEPTH must be a power of two.
module fetch_fifo #(
    parameter type         entry_t = logic [31:0],
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Overflow/underflow guards; a flush legitimately discards everything.
    assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop && !flush));
    assert property (@(posedge clk) disable iff (!rst) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, latency-tolerant imem request/response
// interface and a DEPTH-entry instruction queue feeding decode. Redirects flush the
// queue and arm a drop counter that swallows responses still in flight.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_4
);

    localparam int unsigned   CW     = $clog2(DEPTH + 1);
    localparam logic [CW:0]   QDEPTH = DEPTH[CW:0];
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;
    typedef logic [XLEN-1:0] addr_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   outstanding, q_count;
    logic [CW:0]     credit_used;
    logic            req_fire, rsp_stale, q_push, q_pop;
    logic            q_empty, q_full, pcf_empty, pcf_full;
    entry_t          q_head, q_wdata;
    addr_t           pcf_head;

    // Issue/accept decisions. A request is only issued when a queue slot is reserved
    // for its response, so the queue can never overflow.
    always_comb begin
        credit_used    = {1'b0, outstanding} + {1'b0, q_count};
        imem_req_valid = rst && !redirect_valid && (credit_used < QDEPTH);
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_stale      = (drop_q != '0);
        q_push         = imem_rsp_valid && !rsp_stale && !redirect_valid;
        q_pop          = instr_valid && instr_ready;
        q_wdata        = '{pc: pcf_head, instr: imem_rsp_data};
    end

    // Fetch PC and drop-counter next state; redirect overrides sequential fetch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // A response landing this cycle is discarded here, so it is not counted.
            drop_d     = outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
            if (imem_rsp_valid && rsp_stale) drop_d = drop_q - CW'(1);
        end
    end

    // Fetch PC and drop-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    // Decode-facing outputs come straight from the queue head.
    always_comb begin
        imem_addr   = fetch_pc_q;
        instr_valid = !q_empty;
        instr       = q_head.instr;
        pc          = q_head.pc;
        pc_plus_4   = q_head.pc + STEP;
    end

    fetch_fifo #(
        .entry_t(entry_t),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (q_push),
        .push_data(q_wdata),
        .pop      (q_pop),
        .head     (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    // In-flight address FIFO; its occupancy is the outstanding-request count. It is
    // never flushed: stale responses still pop their address.
    fetch_fifo #(
        .entry_t(addr_t),
        .DEPTH  (DEPTH)
    ) u_inflight (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (req_fire),
        .push_data(fetch_pc_q),
        .pop      (imem_rsp_valid),
        .head     (pcf_head),
        .count    (outstanding),
        .empty    (pcf_empty),
        .full     (pcf_full)
    );

    assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> !pcf_empty);
    assert property (@(posedge clk) disable iff (!rst) req_fire |-> !pcf_full);
    assert property (@(posedge clk) disable iff (!rst) q_push |-> (!q_full || q_pop));
    assert property (@(posedge clk) disable iff (!rst) drop_q <= outstanding);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory plus a queue-level model
// of the fetch stream (in-flight list with stale marks, decode queue, fetch PC).
module tb_fetch_queue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, pc, pc_plus_4;

    fetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .pc            (pc),
        .pc_plus_4     (pc_plus_4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } qent_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;

    flight_t     flight[$];
    qent_t       mq[$];
    memreq_t     memq[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    int          cyc = 0, last_due = -1, lat_min = 1, lat_max = 1, dut_fires = 0;
    int          n_cmp = 0, n_err = 0;
    bit          exp_req_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Drive one cycle's inputs at the falling edge and let outputs settle.
    task automatic begin_cycle(input bit rv, input logic [31:0] rpc, input bit ir, input bit qr);
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = ir;
        imem_req_ready = qr;
        if (rst && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_req_valid = rst && !rv && (flight.size() + mq.size() < DEPTH);
    endtask

    // Advance the model across the coming rising edge.
    task automatic end_cycle();
        flight_t f;
        int      due;
        if (imem_req_valid && imem_req_ready) dut_fires++;
        if (!rst) return;
        if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
        if (imem_rsp_valid) begin
            void'(memq.pop_front());
            f = flight.pop_front();
            if (!f.stale && !redirect_valid) mq.push_back('{pc: f.addr, instr: imem_rsp_data});
        end
        if (redirect_valid) begin
            mq.delete();
            foreach (flight[i]) flight[i].stale = 1'b1;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else if (exp_req_valid && imem_req_ready) begin
            flight.push_back('{addr: m_fetch_pc, stale: 1'b0});
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            memq.push_back('{addr: m_fetch_pc, due: due});
            last_due   = due;
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        imem_req_ready = 1'b0; redirect_pc = '0; imem_rsp_data = '0;
        flight.delete(); mq.delete(); memq.delete();
        m_fetch_pc = RESET_PC;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1; cyc = 0; last_due = -1; dut_fires = 0;
    endtask

    // Run with decode ready until something is delivered; reports what was seen.
    task automatic next_delivery(input int budget, output bit got, output logic [31:0] dpc,
                                 output logic [31:0] dp4, output logic [31:0] dins,
                                 output int waited);
        got = 1'b0; dpc = '0; dp4 = '0; dins = '0; waited = 0;
        for (int k = 0; k < budget && !got; k++) begin
            begin_cycle(1'b0, '0, 1'b1, 1'b1);
            if (instr_valid === 1'b1) begin
                got = 1'b1; dpc = pc; dp4 = pc_plus_4; dins = instr; waited = k;
            end
            end_cycle();
        end
    endtask

    task automatic test_reset();
        assert_reset();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
        n_cmp++; if (pc_plus_4 !== 32'h4) begin n_err++; $display("FAIL reset_pc_plus_4 got %h want 4", pc_plus_4); end
        release_reset();
    endtask

    task automatic test_stream();
        logic [31:0] a, ep;
        assert_reset(); lat_min = 1; lat_max = 1; release_reset();
        for (int c = 0; c < 14; c++) begin
            begin_cycle(1'b0, '0, 1'b1, 1'b1);
            a = imem_addr;
            n_cmp++; if (a[1:0] !== 2'b00) begin n_err++; $display("FAIL stream_addr_align c=%0d got %h", c, a); end
            n_cmp++; if (instr_valid !== (c >= 2)) begin n_err++; $display("FAIL stream_valid c=%0d got %b want %b", c, instr_valid, c >= 2); end
            if (c >= 2) begin
                ep = 32'(4 * (c - 2));
                n_cmp++;
                if (pc !== ep || pc_plus_4 !== ep + 32'd4 || instr !== mem_word(ep)) begin
                    n_err++; $display("FAIL stream_head c=%0d got pc=%h p4=%h ins=%h want pc=%h", c, pc, pc_plus_4, instr, ep);
                end
            end
            end_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen[$];
        assert_reset(); lat_min = 3; lat_max = 3; release_reset();
        for (int c = 0; c < 10; c++) begin begin_cycle(1'b0, '0, 1'b0, 1'b1); end_cycle(); end
        n_cmp++; if (dut_fires != DEPTH) begin n_err++; $display("FAIL bp_requests got %0d want %0d", dut_fires, DEPTH); end
        for (int c = 0; c < 20 && seen.size() < 5; c++) begin
            begin_cycle(1'b0, '0, 1'b1, 1'b1);
            if (instr_valid === 1'b1) seen.push_back(pc);
            end_cycle();
        end
        n_cmp++; if (seen.size() != 5) begin n_err++; $display("FAIL bp_count got %0d want 5", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            n_cmp++; if (seen[i] !== 32'(4 * i)) begin n_err++; $display("FAIL bp_order i=%0d got %h want %h", i, seen[i], 4 * i); end
        end
    endtask

    task automatic test_redirect_inflight();
        bit got; logic [31:0] dpc, dp4, dins; int w;
        assert_reset(); lat_min = 3; lat_max = 3; release_reset();
        repeat (2) begin begin_cycle(1'b0, '0, 1'b1, 1'b1); end_cycle(); end
        begin_cycle(1'b1, 32'h100, 1'b1, 1'b1);
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL redir_no_req got %b want 0", imem_req_valid); end
        end_cycle();
        begin_cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_first_req got v=%b a=%h want 1/100", imem_req_valid, imem_addr); end
        end_cycle();
        next_delivery(12, got, dpc, dp4, dins, w);
        n_cmp++; if (!got) begin n_err++; $display("FAIL redir_timeout got none want pc 100"); end
        n_cmp++; if (dpc !== 32'h100 || dp4 !== 32'h104 || dins !== mem_word(32'h100)) begin n_err++; $display("FAIL redir_target got pc=%h p4=%h ins=%h want 100/104", dpc, dp4, dins); end
        n_cmp++; if (w != 3) begin n_err++; $display("FAIL redir_latency got %0d want 3", w); end
    endtask

    task automatic test_redirect_collision();
        bit got; logic [31:0] dpc, dp4, dins; int w;
        assert_reset(); lat_min = 1; lat_max = 1; release_reset();
        repeat (4) begin begin_cycle(1'b0, '0, 1'b1, 1'b1); end_cycle(); end
        begin_cycle(1'b1, 32'h200, 1'b1, 1'b1);
        n_cmp++; if (instr_valid !== 1'b1 || pc !== 32'h8) begin n_err++; $display("FAIL coll_pop got v=%b pc=%h want 1/8", instr_valid, pc); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL coll_no_req got %b want 0", imem_req_valid); end
        end_cycle();
        begin_cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL coll_flush got %b want 0", instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL coll_req got v=%b a=%h want 1/200", imem_req_valid, imem_addr); end
        end_cycle();
        next_delivery(8, got, dpc, dp4, dins, w);
        n_cmp++; if (!got || dpc !== 32'h200) begin n_err++; $display("FAIL coll_target got %b pc=%h want pc 200", got, dpc); end
    endtask

    task automatic test_misaligned_redirect();
        bit got; logic [31:0] dpc, dp4, dins; int w;
        assert_reset(); lat_min = 2; lat_max = 2; release_reset();
        repeat (2) begin begin_cycle(1'b0, '0, 1'b1, 1'b1); end_cycle(); end
        begin_cycle(1'b1, 32'h103, 1'b1, 1'b1); end_cycle();
        begin_cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL align_addr got v=%b a=%h want 1/100", imem_req_valid, imem_addr); end
        end_cycle();
        begin_cycle(1'b1, 32'h40, 1'b1, 1'b1); end_cycle();
        begin_cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL align_second got %h want 40", imem_addr); end
        end_cycle();
        next_delivery(10, got, dpc, dp4, dins, w);
        n_cmp++; if (!got || dpc !== 32'h40) begin n_err++; $display("FAIL align_drop_stale got %b pc=%h want pc 40", got, dpc); end
        // Back-to-back redirects: the later one, near the top of the address space, wins.
        begin_cycle(1'b1, 32'h80, 1'b1, 1'b1); end_cycle();
        begin_cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1); end_cycle();
        next_delivery(10, got, dpc, dp4, dins, w);
        n_cmp++; if (!got || dpc !== 32'hFFFF_FFFC || dp4 !== 32'h0) begin n_err++; $display("FAIL b2b_wrap got %b pc=%h p4=%h want fffffffc/0", got, dpc, dp4); end
        next_delivery(6, got, dpc, dp4, dins, w);
        n_cmp++; if (!got || dpc !== 32'h0) begin n_err++; $display("FAIL fetch_wrap got %b pc=%h want 0", got, dpc); end
    endtask

    task automatic test_reset_midstream();
        bit got; logic [31:0] dpc, dp4, dins; int w;
        assert_reset(); lat_min = 1; lat_max = 1; release_reset();
        for (int c = 0; c < 10 && mq.size() < 3; c++) begin begin_cycle(1'b0, '0, 1'b0, 1'b1); end_cycle(); end
        assert_reset();
        n_cmp++; if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin n_err++; $display("FAIL mid_reset_clear got v=%b pc=%h ins=%h want 0", instr_valid, pc, instr); end
        n_cmp++; if (imem_req_valid !== 1'b0 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL mid_reset_req got v=%b a=%h want 0/%h", imem_req_valid, imem_addr, RESET_PC); end
        release_reset();
        begin_cycle(1'b0, '0, 1'b1, 1'b1);
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL mid_restart got v=%b a=%h want 1/%h", imem_req_valid, imem_addr, RESET_PC); end
        end_cycle();
        next_delivery(6, got, dpc, dp4, dins, w);
        n_cmp++; if (!got || dpc !== RESET_PC) begin n_err++; $display("FAIL mid_first got %b pc=%h want %h", got, dpc, RESET_PC); end
    endtask

    task automatic test_random();
        bit rv, ir, qr;
        assert_reset(); lat_min = 1; lat_max = 4; release_reset();
        for (int c = 0; c < 1500; c++) begin
            rv = ($urandom_range(15) == 0);
            ir = ($urandom_range(9) < 7);
            qr = ($urandom_range(3) != 0);
            begin_cycle(rv, $urandom, ir, qr);
            n_cmp++; if (imem_req_valid !== exp_req_valid) begin n_err++; $display("FAIL rnd_req_valid c=%0d got %b want %b", c, imem_req_valid, exp_req_valid); end
            if (exp_req_valid) begin
                n_cmp++; if (imem_addr !== m_fetch_pc) begin n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_addr, m_fetch_pc); end
            end
            n_cmp++; if (instr_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid c=%0d got %b want %b", c, instr_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                n_cmp++;
                if (pc !== mq[0].pc || instr !== mq[0].instr || pc_plus_4 !== mq[0].pc + 32'd4) begin
                    n_err++; $display("FAIL rnd_head c=%0d got pc=%h ins=%h p4=%h want pc=%h ins=%h", c, pc, instr, pc_plus_4, mq[0].pc, mq[0].instr);
                end
            end
            end_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_misaligned_redirect();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
